// File: rtl/adventure_move_sequencer.sv
// Move sequencer for the 3x3 adventure grid: accepts direction commands, tracks items and resolves win/dead.
// Optional build macro GAME_WALL_PENALTY_EN: wall bumps are charged against the move budget.
module adventure_move_sequencer #(
    parameter int MAX_MOVES = 31,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dir_valid,
    input  logic [1:0]       dir,
    output logic             dir_ready,
    output logic [3:0]       room,
    output logic             has_sword,
    output logic             has_treasure,
    output logic             win,
    output logic             dead,
    output logic [CNT_W-1:0] move_count
);

    typedef enum logic [2:0] {IDLE, MOVE, RESOLVE, WIN, DEAD} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MOVES);

    state_t           state;
    logic [1:0]       dir_q;
    logic             wall;
    logic [3:0]       target;
    logic             charge;
    logic [CNT_W-1:0] cnt_sat_inc;

    // Walls are detected straight from the room index; no row/col registers needed.
    always_comb begin
        wall   = 1'b0;
        target = room;
        case (dir_q)
            2'd0: if (room < 4'd3)                    wall = 1'b1; else target = room - 4'd3;
            2'd1: if (room inside {4'd2, 4'd5, 4'd8}) wall = 1'b1; else target = room + 4'd1;
            2'd2: if (room > 4'd5)                    wall = 1'b1; else target = room + 4'd3;
            default: if (room inside {4'd0, 4'd3, 4'd6}) wall = 1'b1; else target = room - 4'd1;
        endcase
    end

`ifdef GAME_WALL_PENALTY_EN
    assign charge = 1'b1;
`else
    assign charge = !wall;
`endif

    assign cnt_sat_inc = (move_count == MAX_CNT) ? move_count : move_count + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            dir_q        <= 2'd0;
            dir_ready    <= 1'b1;
            room         <= 4'd0;
            has_sword    <= 1'b0;
            has_treasure <= 1'b0;
            win          <= 1'b0;
            dead         <= 1'b0;
            move_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dir_valid && dir_ready) begin
                        dir_q     <= dir;
                        dir_ready <= 1'b0;
                        state     <= MOVE;
                    end
                end
                MOVE: begin
                    room <= target;
                    if (charge)
                        move_count <= cnt_sat_inc;
                    state <= RESOLVE;
                end
                RESOLVE: begin
                    if (room == 4'd2)
                        has_sword <= 1'b1;
                    if (room == 4'd7)
                        has_treasure <= 1'b1;
                    // Win is checked before the budget so a winning final move still wins.
                    if (room == 4'd5 && !has_sword) begin
                        dead  <= 1'b1;
                        state <= DEAD;
                    end else if (room == 4'd0 && has_treasure) begin
                        win   <= 1'b1;
                        state <= WIN;
                    end else if (move_count == MAX_CNT) begin
                        dead  <= 1'b1;
                        state <= DEAD;
                    end else begin
                        dir_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adventure_move_sequencer.sv
// Directed bench for adventure_move_sequencer: grid-level model checked every cycle plus literal spot checks.
module tb_adventure_move_sequencer;

    localparam int MAX_MOVES = 31;
    localparam int CNT_W     = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             dir_valid;
    logic [1:0]       dir;
    logic             dir_ready;
    logic [3:0]       room;
    logic             has_sword;
    logic             has_treasure;
    logic             win;
    logic             dead;
    logic [CNT_W-1:0] move_count;

    adventure_move_sequencer #(.MAX_MOVES(MAX_MOVES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .dir_valid(dir_valid), .dir(dir), .dir_ready(dir_ready),
        .room(room), .has_sword(has_sword), .has_treasure(has_treasure),
        .win(win), .dead(dead), .move_count(move_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int exp_room, exp_cnt, exp_sword, exp_treas, exp_win, exp_dead, exp_ready;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        exp_room = 0; exp_cnt = 0; exp_sword = 0; exp_treas = 0;
        exp_win = 0; exp_dead = 0; exp_ready = 1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("room", int'(room), exp_room);
            chk("move_count", int'(move_count), exp_cnt);
            chk("has_sword", int'(has_sword), exp_sword);
            chk("has_treasure", int'(has_treasure), exp_treas);
            chk("win", int'(win), exp_win);
            chk("dead", int'(dead), exp_dead);
            chk("dir_ready", int'(dir_ready), exp_ready);
            chk("win_dead_exclusive", int'(win && dead), 0);
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One command: offered at a negedge, model advanced one step per edge after acceptance.
    task automatic send(input logic [1:0] d);
        int r, c, nr, nc;
        bit legal;
        @(negedge clk);
        dir_valid = 1'b1;
        dir       = d;
        @(posedge clk); #1;
        if (exp_ready == 0) begin
            // Terminal: command is ignored, keep it offered for two more cycles.
            repeat (2) @(posedge clk);
            #1;
            dir_valid = 1'b0;
            return;
        end
        dir_valid = 1'b0;
        exp_ready = 0;
        r = exp_room / 3; c = exp_room % 3; nr = r; nc = c;
        case (d)
            2'd0: nr = r - 1;
            2'd1: nc = c + 1;
            2'd2: nr = r + 1;
            default: nc = c - 1;
        endcase
        legal = (nr >= 0 && nr <= 2 && nc >= 0 && nc <= 2);
        @(posedge clk); #1;
        if (legal) exp_room = nr * 3 + nc;
`ifdef GAME_WALL_PENALTY_EN
        if (exp_cnt < MAX_MOVES) exp_cnt++;
`else
        if (legal && exp_cnt < MAX_MOVES) exp_cnt++;
`endif
        @(posedge clk); #1;
        if (exp_room == 2) exp_sword = 1;
        if (exp_room == 7) exp_treas = 1;
        if (exp_room == 5 && exp_sword == 0) exp_dead = 1;
        else if (exp_room == 0 && exp_treas == 1) exp_win = 1;
        else if (exp_cnt == MAX_MOVES) exp_dead = 1;
        exp_ready = (exp_win == 0 && exp_dead == 0) ? 1 : 0;
    endtask

    initial begin
        reset     = 1'b1;
        dir_valid = 1'b0;
        dir       = 2'd0;
        model_reset();
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_room", int'(room), 0);
        chk("rst_ready", int'(dir_ready), 1);
        chk("rst_cnt", int'(move_count), 0);

        // S,E,E walks into the dragon unarmed
        send(2); send(1); send(1);
        chk("see_room", int'(room), 5);
        chk("see_dead", int'(dead), 1);
        chk("see_cnt", int'(move_count), 3);
        repeat (3) send(1);
        chk("see_ignored_room", int'(room), 5);
        chk("see_ready", int'(dir_ready), 0);

        // Full winning tour
        do_reset();
        send(1); send(1); send(2); send(2); send(3); send(3); send(0); send(0);
        chk("tour_win", int'(win), 1);
        chk("tour_dead", int'(dead), 0);
        chk("tour_cnt", int'(move_count), 8);
        chk("tour_room", int'(room), 0);
        chk("tour_sword", int'(has_sword), 1);
        chk("tour_treasure", int'(has_treasure), 1);

        // Wall bump north from room 0
        do_reset();
        send(0);
        chk("wall_room", int'(room), 0);
`ifdef GAME_WALL_PENALTY_EN
        chk("wall_cnt", int'(move_count), 1);
`else
        chk("wall_cnt", int'(move_count), 0);
`endif

        // Budget exhaustion by shuffling E/W
        do_reset();
        for (int i = 0; i < MAX_MOVES; i++) send((i % 2 == 0) ? 2'd1 : 2'd3);
        chk("budget_dead", int'(dead), 1);
        chk("budget_win", int'(win), 0);
        chk("budget_cnt", int'(move_count), 31);
        chk("budget_room", int'(room), 1);

        // Reset while the third command is in MOVE
        do_reset();
        send(1); send(1);
        @(negedge clk);
        dir_valid = 1'b1;
        dir       = 2'd2;
        @(posedge clk); #1;
        dir_valid = 1'b0;
        reset     = 1'b1;
        model_reset();
        #1;
        chk("abort_room", int'(room), 0);
        chk("abort_sword", int'(has_sword), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        send(2);
        chk("after_abort_room", int'(room), 3);
        chk("after_abort_cnt", int'(move_count), 1);
        chk("after_abort_sword", int'(has_sword), 0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
